// File: rtl/k12a_fetch_ctrl.sv
// rtl/k12a_fetch_ctrl.sv - k12a two-byte instruction-fetch sequencer
// Optional per-byte wait timeout is compiled in with K12A_FETCH_TIMEOUT_EN.
`timescale 1ns/1ps

module k12a_fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] pc,
  input  logic        mem_ready,
  inout  wire  [15:0] addr_bus,
  output logic        mem_read_n,
  output logic        inst_high_store,
  output logic        inst_low_store,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        fetch_error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HI_REQ = 3'd1,
    LO_REQ = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        drive_addr;
  logic [15:0] addr_out;

`ifdef K12A_FETCH_TIMEOUT_EN
  localparam int WaitW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout;
  logic [WaitW-1:0] wait_inc;

  assign timeout  = (wait_cnt_q == WaitW'(TIMEOUT_CYCLES));
  // Saturate at the limit; the abort fires there anyway.
  assign wait_inc = timeout ? wait_cnt_q : wait_cnt_q + WaitW'(1);
`endif

  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= 16'h0000;
`ifdef K12A_FETCH_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
`ifdef K12A_FETCH_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drive_addr      = 1'b0;
    addr_out        = pc_q;
    mem_read_n      = 1'b1;
    inst_high_store = 1'b0;
    inst_low_store  = 1'b0;
    fetch_done      = 1'b0;
    fetch_error     = 1'b0;
`ifdef K12A_FETCH_TIMEOUT_EN
    wait_cnt_d      = wait_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          pc_d    = pc;
          state_d = HI_REQ;
`ifdef K12A_FETCH_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      HI_REQ: begin
        drive_addr      = 1'b1;
        addr_out        = pc_q;
        mem_read_n      = 1'b0;
        inst_high_store = mem_ready;
        if (mem_ready) begin
          state_d = LO_REQ;
`ifdef K12A_FETCH_TIMEOUT_EN
          wait_cnt_d = '0;
        end else if (timeout) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_inc;
`endif
        end
      end

      LO_REQ: begin
        drive_addr     = 1'b1;
        addr_out       = pc_q + 16'd1;
        mem_read_n     = 1'b0;
        inst_low_store = mem_ready;
        if (mem_ready) begin
          state_d = DONE;
`ifdef K12A_FETCH_TIMEOUT_EN
        end else if (timeout) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_inc;
`endif
        end
      end

      DONE: begin
        fetch_done = 1'b1;
        state_d    = IDLE;
      end

      ERR: begin
`ifdef K12A_FETCH_TIMEOUT_EN
        fetch_error = 1'b1;
`endif
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign fetch_busy = (state_q != IDLE);
  assign addr_bus   = drive_addr ? addr_out : 16'hzzzz;

endmodule

// File: tb/tb_k12a_fetch_ctrl.sv
// tb/tb_k12a_fetch_ctrl.sv - scoreboard bench for k12a_fetch_ctrl
`timescale 1ns/1ps

module tb_k12a_fetch_ctrl;

  localparam int K_HI   = 0;
  localparam int K_LO   = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int          kind;
    logic [15:0] addr;
    int          cyc;
  } exp_t;

  logic        cpu_clock = 1'b0;
  logic        reset     = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] pc        = 16'h0000;
  logic        mem_ready = 1'b0;
  wire  [15:0] addr_bus;
  logic        mem_read_n;
  logic        inst_high_store;
  logic        inst_low_store;
  logic        fetch_busy;
  logic        fetch_done;
  logic        fetch_error;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  k12a_fetch_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .cpu_clock       (cpu_clock),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .pc              (pc),
    .mem_ready       (mem_ready),
    .addr_bus        (addr_bus),
    .mem_read_n      (mem_read_n),
    .inst_high_store (inst_high_store),
    .inst_low_store  (inst_low_store),
    .fetch_busy      (fetch_busy),
    .fetch_done      (fetch_done),
    .fetch_error     (fetch_error)
  );

  always #5 cpu_clock = ~cpu_clock;

  always @(posedge cpu_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void push_exp(input int kind, input logic [15:0] addr, input int at);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.cyc  = at;
    sb_q.push_back(e);
  endfunction

  task automatic pop_check(input int kind, input logic [15:0] addr);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind %0d addr %h at cycle %0d, none expected", kind, addr, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind <= K_LO && addr !== e.addr)) begin
        errors++;
        $display("FAIL event got kind %0d addr %h cycle %0d expected kind %0d addr %h cycle %0d",
                 kind, addr, cyc, e.kind, e.addr, e.cyc);
      end
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard at each falling edge.
  always @(negedge cpu_clock) begin
    if (!reset) begin
      if (!mem_read_n && sb_q.size() > 0 && sb_q[0].kind <= K_LO)
        check("addr_bus_during_read", {16'h0, addr_bus}, {16'h0, sb_q[0].addr});
      if (inst_high_store || inst_low_store) begin
        check("strobe_exclusive", {31'h0, inst_high_store & inst_low_store}, 32'h0);
        check("strobe_with_read", {31'h0, mem_read_n}, 32'h0);
      end
      if (inst_high_store) pop_check(K_HI, addr_bus);
      if (inst_low_store)  pop_check(K_LO, addr_bus);
      if (fetch_done)      pop_check(K_DONE, 16'h0);
      if (fetch_error)     pop_check(K_ERR, 16'h0);
    end
  end

  task automatic do_fetch(input logic [15:0] a, input int wh, input int wl,
                          input bit chg_pc, input bit hold_req);
    int c;
    c = cyc;
    fetch_req = 1'b1;
    pc        = a;
    push_exp(K_HI,   a,         c + 1 + wh);
    push_exp(K_LO,   a + 16'd1, c + 2 + wh + wl);
    push_exp(K_DONE, 16'h0,     c + 3 + wh + wl);
    @(posedge cpu_clock); #1;
    fetch_req = 1'b0;
    if (chg_pc) pc = 16'h4000;
    check("busy_in_fetch", {31'h0, fetch_busy}, 32'h1);
    repeat (wh) begin
      mem_ready = 1'b0;
      @(posedge cpu_clock); #1;
    end
    mem_ready = 1'b1;
    @(posedge cpu_clock); #1;
    repeat (wl) begin
      mem_ready = 1'b0;
      @(posedge cpu_clock); #1;
    end
    mem_ready = 1'b1;
    @(posedge cpu_clock); #1;
    fetch_req = hold_req;
    @(posedge cpu_clock); #1;
    check("idle_after_done", {31'h0, fetch_busy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    #2;
    check("rst_busy",       {31'h0, fetch_busy},      32'h0);
    check("rst_mem_read_n", {31'h0, mem_read_n},      32'h1);
    check("rst_high",       {31'h0, inst_high_store}, 32'h0);
    check("rst_low",        {31'h0, inst_low_store},  32'h0);
    check("rst_done",       {31'h0, fetch_done},      32'h0);
    check("rst_error",      {31'h0, fetch_error},     32'h0);
    repeat (2) @(posedge cpu_clock);
    #1;
    reset = 1'b0;
    @(posedge cpu_clock); #1;

    do_fetch(16'h1234, 0, 0, 1'b0, 1'b0);
    do_fetch(16'hFFFF, 0, 0, 1'b0, 1'b0);
    do_fetch(16'h0100, 3, 2, 1'b0, 1'b0);
    do_fetch(16'h2000, 1, 0, 1'b1, 1'b1);
    do_fetch(16'h4000, 0, 1, 1'b0, 1'b0);

    // Reset while the low byte is outstanding.
    c = cyc;
    fetch_req = 1'b1;
    pc        = 16'h5A5A;
    mem_ready = 1'b1;
    push_exp(K_HI, 16'h5A5A, c + 1);
    @(posedge cpu_clock); #1;
    fetch_req = 1'b0;
    @(posedge cpu_clock); #1;
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_mem_read_n", {31'h0, mem_read_n},      32'h1);
    check("midrst_high",       {31'h0, inst_high_store}, 32'h0);
    check("midrst_low",        {31'h0, inst_low_store},  32'h0);
    check("midrst_busy",       {31'h0, fetch_busy},      32'h0);
    check("midrst_done",       {31'h0, fetch_done},      32'h0);
    mem_ready = 1'b1;
    @(posedge cpu_clock); #1;
    check("midrst_low_held",   {31'h0, inst_low_store},  32'h0);
    @(posedge cpu_clock); #1;
    reset = 1'b0;
    repeat (4) @(posedge cpu_clock);
    #1;
    check("postrst_busy", {31'h0, fetch_busy}, 32'h0);

`ifdef K12A_FETCH_TIMEOUT_EN
    c = cyc;
    fetch_req = 1'b1;
    pc        = 16'h0800;
    mem_ready = 1'b0;
    push_exp(K_ERR, 16'h0, c + 6);
    @(posedge cpu_clock); #1;
    fetch_req = 1'b0;
    repeat (6) @(posedge cpu_clock);
    #1;
    check("busy_after_err", {31'h0, fetch_busy}, 32'h0);
    do_fetch(16'h0900, 4, 4, 1'b0, 1'b0);
`endif

    repeat (3) @(posedge cpu_clock);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
